bus_ram_responder: RTL

Single-port, word-organised RAM acting as the responder on the CPU system bus. It samples the initiator's address, write data and write strobe. After a programmable number of wait states it pulses `bus_ready` for exactly one cycle, presenting read data and committing any write on that cycle. It sits directly on the `cpu` bus port and serves both instruction fetches and load/store accesses.

---
 rtl/bus_ram_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bus_ram_responder.sv
// -----------------------------------------------------------------------------
// bus_ram_responder
//
// Word-organised single-port RAM that answers the CPU system bus. Every cycle
// the bus is treated as requesting. An access is captured, optionally held for
// a number of wait states, and then completed with a one-cycle bus_ready pulse.
// Read data reflects memory contents before any write. A write commits at the
// clock edge that ends the response cycle.
//
// Handshake: there is no request strobe. The responder captures bus_addr,
// bus_we and bus_wdata in CAPTURE. The initiator holds bus_addr and bus_we
// stable until it sees bus_ready=1. bus_ready is high for exactly one cycle per
// access, and bus_rdata is valid only in that cycle. A change of word index or
// bus_we while waiting restarts the access. A bus_wdata change alone does not.
//
// Optional feature macro: BUS_RAM_WAIT_EN
//   defined   : the wait counter, the WAIT state and the restart-on-change logic
//               are compiled in, and WAIT_STATES is honoured.
//   undefined : each access is CAPTURE -> RESP, with bus_ready every 2nd cycle.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   WAIT_STATES wait cycles between capture and response (0..15)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   bus_addr   byte address; word index = bus_addr[31:2]
//   bus_wdata  write data
//   bus_we     1 = write, 0 = read
//   bus_rdata  registered read data, valid while bus_ready=1
//   bus_ready  one-cycle completion pulse
//   err_oor    sticky flag: an access hit index >= DEPTH (cleared by reset)
//   dbg_state  current FSM state (0 CAPTURE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module bus_ram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        err_oor,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [29:0] live_idx;
  logic [29:0] lat_idx;
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic        relatch;   // load the access latches from the live bus this edge
  logic [29:0] rd_idx;
  logic        rd_oor;
  logic        lat_oor;

  // The byte-lane bits of the address do not select anything.
  logic unused_byte_bits;
  assign unused_byte_bits = ^bus_addr[1:0];

  logic [31:0] mem [DEPTH];

  assign live_idx  = bus_addr[31:2];
  assign dbg_state = state;

  // The read for the response happens on the edge that enters RESP. Coming
  // straight from CAPTURE, the latches are loaded on that same edge, so the
  // live index is used. From WAIT, entry only happens on a match, so the
  // latched index is the same as the live one.
  assign rd_idx  = (state == ST_CAPTURE) ? live_idx : lat_idx;
  assign rd_oor  = ({2'b00, rd_idx}  >= DEPTH_W);
  assign lat_oor = ({2'b00, lat_idx} >= DEPTH_W);

`ifdef BUS_RAM_WAIT_EN
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [3:0] wait_cnt;
  logic [3:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= cnt_next;
    end
  end
`else
  // With the wait logic compiled out, the wait-state count has no effect.
  localparam int unsigned unused_wait_states = WAIT_STATES;
`endif

  always_comb begin
    state_next = state;
    relatch    = 1'b0;
`ifdef BUS_RAM_WAIT_EN
    cnt_next   = wait_cnt;
`endif
    case (state)
      ST_CAPTURE: begin
        relatch = 1'b1;
`ifdef BUS_RAM_WAIT_EN
        cnt_next   = WS;
        state_next = (WS != 4'd0) ? ST_WAIT : ST_RESP;
`else
        state_next = ST_RESP;
`endif
      end
      ST_WAIT: begin
`ifdef BUS_RAM_WAIT_EN
        if ((live_idx != lat_idx) || (bus_we != lat_we)) begin
          // The initiator moved: restart the whole access on the new request.
          relatch  = 1'b1;
          cnt_next = WS;
        end else begin
          cnt_next = wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state_next = ST_RESP;
          end
        end
`else
        state_next = ST_CAPTURE;
`endif
      end
      ST_RESP: begin
        state_next = ST_CAPTURE;
      end
      default: begin
        state_next = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CAPTURE;
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      err_oor   <= 1'b0;
    end else begin
      state     <= state_next;
      bus_ready <= (state_next == ST_RESP);
      if (relatch) begin
        lat_idx   <= live_idx;
        lat_we    <= bus_we;
        lat_wdata <= bus_wdata;
      end
      if (state_next == ST_RESP) begin
        bus_rdata <= rd_oor ? 32'h0 : mem[rd_idx[AW-1:0]];
        // Registered on RESP entry so the flag is already high in RESP.
        if (rd_oor) begin
          err_oor <= 1'b1;
        end
      end
    end
  end

  // Memory contents are not reset. A reset on the RESP edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_RESP) && lat_we && !lat_oor) begin
      mem[lat_idx[AW-1:0]] <= lat_wdata;
    end
  end

endmodule
